// File: rtl/proc_pkg.sv
// Shared definitions for the processor special-register slice: PSR bit layout,
// PC sequencing encodings and a PSR masking helper.
package proc_pkg;

    // PSR bit positions
    localparam int C_IND = 0;
    localparam int L_IND = 2;
    localparam int F_IND = 5;
    localparam int Z_IND = 6;
    localparam int N_IND = 7;
    localparam int E_IND = 9;

    // Only the bits listed above exist; everything else reads as zero
    localparam logic [15:0] PSR_MASK = 16'h02E5;

    // PC sequencing modes selected by pc_sel
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_REL  = 2'd2,
        PC_ABS  = 2'd3
    } pc_sel_e;

    // Strip undefined PSR bits so they can never become set
    function automatic logic [15:0] psr_mask_f(input logic [15:0] value);
        return value & PSR_MASK;
    endfunction

endpackage

// File: rtl/proc_special_regs_if.sv
// Control/status bundle between the control FSM (master) and the
// special-register file (slave).
interface proc_special_regs_if #(
    parameter int PC_WIDTH     = 21,
    parameter int INSTR_WIDTH  = 16,
    parameter int SHADOW_DEPTH = 4
);
    localparam int DW = $clog2(SHADOW_DEPTH + 1);

    logic                   pc_en;
    logic [1:0]             pc_sel;
    logic [PC_WIDTH-1:0]    pc_operand;
    logic                   instr_en;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic                   cmp_f_en;
    logic                   of_f_en;
    logic                   z_f_en;
    logic                   C_in;
    logic                   L_in;
    logic                   F_in;
    logic                   Z_in;
    logic                   N_in;
    logic                   psr_wr_en;
    logic [15:0]            psr_wd;
    logic                   irq_take;
    logic                   irq_ret;
    logic                   irq_ack;
    logic                   stack_err;
    logic [DW-1:0]          int_depth;
    logic [15:0]            psr;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;

    modport master (
        output pc_en, pc_sel, pc_operand, instr_en, instr_in,
               cmp_f_en, of_f_en, z_f_en, C_in, L_in, F_in, Z_in, N_in,
               psr_wr_en, psr_wd, irq_take, irq_ret,
        input  irq_ack, stack_err, int_depth, psr, instr, pc
    );

    modport slave (
        input  pc_en, pc_sel, pc_operand, instr_en, instr_in,
               cmp_f_en, of_f_en, z_f_en, C_in, L_in, F_in, Z_in, N_in,
               psr_wr_en, psr_wd, irq_take, irq_ret,
        output irq_ack, stack_err, int_depth, psr, instr, pc
    );

endinterface

// File: rtl/shadow_stack.sv
// LIFO holding {PSR, PC} frames for nested interrupts. Overflow/underflow
// requests are ignored here; the caller decides what they mean.
module shadow_stack #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int DW = $clog2(DEPTH + 1),
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    top_s;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == {DW{1'b0}});
    assign depth = depth_q;
    assign top_s = depth_q - {{(DW-1){1'b0}}, 1'b1};

    // Frame storage and depth counter; push takes precedence over pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= {DW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !full) begin
            mem_q[depth_q[IW-1:0]] <= din;
            depth_q                <= depth_q + {{(DW-1){1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            depth_q <= top_s;
        end else begin
            depth_q <= depth_q;
        end
    end

    // Top-of-stack view; gated so stale frames are never visible when empty
    always_comb begin
        if (empty) begin
            dout = {WIDTH{1'b0}};
        end else begin
            dout = mem_q[top_s[IW-1:0]];
        end
    end

endmodule

// File: rtl/proc_special_regs.sv
// Processor special registers (PSR, PC, INSTR) with a shadow stack that
// saves {PSR, PC} on interrupt entry and restores it on return.
module proc_special_regs
    import proc_pkg::*;
#(
    parameter int          PC_WIDTH     = 21,
    parameter int          INSTR_WIDTH  = 16,
    parameter int unsigned RESET_PC     = 32'd0,
    parameter int unsigned INT_VECTOR   = 32'h100,
    parameter int          SHADOW_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    proc_special_regs_if.slave  bus
);

    localparam int DW = $clog2(SHADOW_DEPTH + 1);
    localparam int FW = 16 + PC_WIDTH;

    logic [PC_WIDTH-1:0]    pc_q,    pc_d;
    logic [15:0]            psr_q,   psr_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   ack_q,   ack_d;
    logic                   err_q,   err_d;

    logic          push_s, pop_s, full_s, empty_s;
    logic          take_ok_s, take_fail_s, ret_ok_s, ret_fail_s, irq_any_s;
    logic [FW-1:0] frame_in_s, frame_out_s;
    logic [DW-1:0] depth_s;

    shadow_stack #(
        .WIDTH (FW),
        .DEPTH (SHADOW_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (frame_in_s),
        .dout  (frame_out_s),
        .depth (depth_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Interrupt arbitration: take beats return; failed requests still block other updates
    always_comb begin
        take_ok_s   = bus.irq_take && !full_s;
        take_fail_s = bus.irq_take && full_s;
        ret_ok_s    = !bus.irq_take && bus.irq_ret && !empty_s;
        ret_fail_s  = !bus.irq_take && bus.irq_ret && empty_s;
        irq_any_s   = bus.irq_take || bus.irq_ret;
        push_s      = take_ok_s;
        pop_s       = ret_ok_s;
        frame_in_s  = {psr_q, pc_q};
    end

    // PC next state: vector / restore / sequencing mode
    always_comb begin
        pc_d = pc_q;
        if (take_ok_s) begin
            pc_d = PC_WIDTH'(INT_VECTOR);
        end else if (ret_ok_s) begin
            pc_d = frame_out_s[PC_WIDTH-1:0];
        end else if (irq_any_s) begin
            pc_d = pc_q;
        end else if (bus.pc_en) begin
            case (bus.pc_sel)
                PC_HOLD: pc_d = pc_q;
                PC_INC:  pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                PC_REL:  pc_d = pc_q + bus.pc_operand;
                PC_ABS:  pc_d = bus.pc_operand;
                default: pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // PSR next state: interrupt save/restore, software write, then flag groups
    always_comb begin
        psr_d = psr_q;
        if (take_ok_s) begin
            psr_d[E_IND] = 1'b0;
        end else if (ret_ok_s) begin
            psr_d = psr_mask_f(frame_out_s[FW-1:PC_WIDTH]);
        end else if (irq_any_s) begin
            psr_d = psr_q;
        end else if (bus.psr_wr_en) begin
            psr_d = psr_mask_f(bus.psr_wd);
        end else begin
            if (bus.cmp_f_en) begin
                psr_d[L_IND] = bus.L_in;
                psr_d[N_IND] = bus.N_in;
            end
            if (bus.of_f_en) begin
                psr_d[F_IND] = bus.F_in;
                psr_d[C_IND] = bus.C_in;
            end
            if (bus.z_f_en) begin
                psr_d[Z_IND] = bus.Z_in;
            end
        end
    end

    // Instruction register and status outputs next state
    always_comb begin
        instr_d = bus.instr_en ? bus.instr_in : instr_q;
        ack_d   = take_ok_s;
        err_d   = err_q || take_fail_s || ret_fail_s;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_WIDTH'(RESET_PC);
            psr_q   <= 16'h0000;
            instr_q <= {INSTR_WIDTH{1'b0}};
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            psr_q   <= psr_d;
            instr_q <= instr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.psr       = psr_q;
    assign bus.instr     = instr_q;
    assign bus.irq_ack   = ack_q;
    assign bus.stack_err = err_q;
    assign bus.int_depth = depth_s;

endmodule
